mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequences the single data-memory access for the instruction held in the EX/MEM pipeline register. It decodes load/store opcode and funct3, drives a request/grant/response data-memory port with word address and byte enables, and stalls the pipeline until the access completes. It returns sign- or zero-extended load data to the MEM/WB path. It sits between the EX/MEM register outputs and the data memory.

## Interface
- TIMEOUT, 64: maximum cycles to wait for `dmem_rvalid_i` after grant before flagging a bus error (≥2).
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- valid_i  in  1  EX/MEM holds a live instruction
- flush_i  in  1  kill the current instruction
- opcode_i  in  7  EX/MEM opcode
- funct3_i  in  3  EX/MEM funct3
- addr_i  in  32  effective address (EX/MEM ALU result)
- wdata_i  in  32  store data (EX/MEM rs2 data)
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word address, bits [1:0] = 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read word
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- load_valid_o  out  1  one-cycle load-completion pulse
- load_data_o  out  32  extended load result
- bus_err_o  out  1  one-cycle timeout pulse

## Operation
- Load: opcode 7'b0000011. Store: opcode 7'b0100011. Other opcodes bypass the block and never stall.
- Width: funct3[1:0] 00 = byte, 01 = half, 10 = word. Loads with funct3[2] = 1 are zero-extended; otherwise sign-extended.
- Byte enables: byte = 4'b0001 << addr[1:0]. Half = 4'b0011 << {addr[1],1'b0}. Word = 4'b1111.
- Store data is replicated or shifted into the lane selected by addr[1:0].
- Load data is shifted down by addr[1:0] lanes, then extended.
- `start` = valid_i & (load | store) & ~flush_i, evaluated in IDLE.
- FSM states:
  - IDLE: on `start`, latch the request and go to REQ.
  - REQ: hold `dmem_req_o`. On gnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: on rvalid, capture the data and go to DONE. After TIMEOUT cycles without rvalid, pulse `bus_err_o` and go to IDLE.
  - DONE: one cycle, then IDLE.
- `stall_o` is combinational: (IDLE & start) | REQ | WAIT.
- Flush:
  - In REQ before gnt: drop the request and return to IDLE.
  - In WAIT: the access runs to completion, but `load_valid_o` is suppressed.
  - A gnt and a flush in the same cycle count as granted.
- Misaligned handling (half with addr[0] = 1, word with addr[1:0] ≠ 0) is governed by the macro below.

## Timing
- Reset values:
  - Outputs: req/we/be/addr/wdata = 0; load_valid/bus_err = 0; load_data = 0.
  - Internal: state = IDLE; wait counter = 0.
- Bus outputs and load_data_o are registered. stall_o is combinational.
- Store with immediate gnt: cycle 0 start (stall = 1); cycle 1 REQ with gnt (stall = 1); cycle 2 DONE (stall = 0). Total 2 stall cycles.
- Load with immediate gnt and rvalid one cycle later: cycle 0 start, cycle 1 REQ, cycle 2 WAIT with rvalid, cycle 3 DONE. `load_valid_o` and `load_data_o` are valid in cycle 3; 3 stall cycles.
- rvalid arriving in the same cycle as gnt is not supported; rvalid must come at least one cycle after gnt.
- The wait counter is 0 on entry to WAIT. The timeout fires in the cycle where the count reaches TIMEOUT-1.
- rst_n asserted mid-access returns to IDLE immediately and drops req. No pulse is emitted.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access produces no bus request.
  - Extra output `misalign_o` (1 bit, reset 0) pulses for one cycle, in the cycle after start.
  - stall_o is 1 only in the start cycle.
- MEM_MISALIGN_TRAP_EN undefined:
  - Address bits that do not fit the access size are ignored: the address is forced to natural alignment.
  - `misalign_o` is absent.

## Structure
- Shared package/defines (`define.v`): OPCODE_LOAD, OPCODE_STORE, the funct3 width codes, and the FSM state encodings.
- One sub-module, `mem_lane_align`: combinational byte-enable, store-shift and load-extract/extend logic. The FSM, counter and registers stay in the top module.

## Test plan
- SW to 0x100, data 0xDEADBEEF, gnt in the first REQ cycle -> addr 0x100, be 4'b1111, we = 1, stall high for exactly 2 cycles.
- LB from 0x103, rdata 0x80FFFFFF -> be 4'b1000, load_data 0xFFFFFF80; LBU on the same access -> 0x00000080.
- SH to 0x102, data 0x0000ABCD -> be 4'b1100, wdata[31:16] = 0xABCD. gnt held off 3 cycles -> req stays high, stall lasts 5 cycles.
- LW with rvalid never returned, TIMEOUT = 64 -> bus_err pulse, back to IDLE, stall released, no load_valid.
- flush_i in REQ before gnt -> req drops the next cycle and no access occurs. flush_i in WAIT -> access completes and load_valid stays 0.
- LW to 0x102 -> with the macro: misalign pulse, no req. Without it: addr 0x100, be 4'b1111.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared opcode, access-width and FSM state constants for the
//               data-memory access controller, plus a misalignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    // Opcodes that route through the data-memory port
    localparam logic [6:0] c_opcode_load  = 7'b0000011;
    localparam logic [6:0] c_opcode_store = 7'b0100011;

    // Access width, taken from funct3[1:0]
    localparam logic [1:0] c_width_byte = 2'b00;
    localparam logic [1:0] c_width_half = 2'b01;
    localparam logic [1:0] c_width_word = 2'b10;

    // Access sequencer states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // An access is misaligned when the address has bits set below its size.
    // The unused width code 2'b11 is treated as a word access.
    function automatic logic f_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic w_mis;
        case (funct3[1:0])
            c_width_byte: w_mis = 1'b0;
            c_width_half: w_mis = addr_lo[0];
            default:      w_mis = |addr_lo;
        endcase
        return w_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane logic: byte enables, store-data lane
//               placement and load-data extraction with sign/zero extension.
//               The address offset is forced to natural alignment for the
//               access size, so low address bits that do not fit are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_result
);

    logic [1:0]  w_off;
    logic [31:0] w_shifted;

    // Select byte enables, replicate store data and extend the load result
    always_comb begin
        w_off       = 2'b00;
        be          = 4'b1111;
        store_lanes = store_data;
        case (funct3[1:0])
            c_width_byte: begin
                w_off       = addr_lo;
                be          = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
            end
            c_width_half: begin
                w_off       = {addr_lo[1], 1'b0};
                be          = 4'b0011 << {addr_lo[1], 1'b0};
                store_lanes = {2{store_data[15:0]}};
            end
            default: begin
                w_off       = 2'b00;
                be          = 4'b1111;
                store_lanes = store_data;
            end
        endcase

        w_shifted = load_word >> {w_off, 3'b000};

        case (funct3[1:0])
            c_width_byte: load_result = funct3[2] ? {24'd0, w_shifted[7:0]}
                                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_width_half: load_result = funct3[2] ? {16'd0, w_shifted[15:0]}
                                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:      load_result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences the single data-memory access of the instruction in
//               EX/MEM over a req/gnt/rvalid port, stalls the pipeline until
//               it completes and returns extended load data.
//               Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses
//               raise a one-cycle misalign_o pulse instead of a bus request.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        bus_err_o
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_is_load;
    logic               r_flushed;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;

    logic               w_is_load;
    logic               w_is_store;
    logic               w_start;
    logic               w_go;
    logic [2:0]         w_sel_funct3;
    logic [1:0]         w_sel_addr_lo;
    logic [3:0]         w_be;
    logic [31:0]        w_store_lanes;
    logic [31:0]        w_load_result;

    assign w_is_load  = (opcode_i == c_opcode_load);
    assign w_is_store = (opcode_i == c_opcode_store);
    assign w_start    = valid_i & (w_is_load | w_is_store) & ~flush_i;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = f_misaligned(funct3_i, addr_i[1:0]);
    assign w_go         = w_start & ~w_misaligned;
`else
    assign w_go         = w_start;
`endif

    // The store lanes are formed from live inputs in IDLE; the load result
    // uses the size/offset latched when the access started.
    assign w_sel_funct3  = (r_state == c_st_idle) ? funct3_i    : r_funct3;
    assign w_sel_addr_lo = (r_state == c_st_idle) ? addr_i[1:0] : r_addr_lo;

    mem_lane_align u_lane_align (
        .funct3      (w_sel_funct3),
        .addr_lo     (w_sel_addr_lo),
        .store_data  (wdata_i),
        .load_word   (dmem_rdata_i),
        .be          (w_be),
        .store_lanes (w_store_lanes),
        .load_result (w_load_result)
    );

    assign stall_o = ((r_state == c_st_idle) & w_start) |
                     (r_state == c_st_req) | (r_state == c_st_wait);

    // Access sequencer with registered bus outputs and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_wait_cnt   <= '0;
            r_is_load    <= 1'b0;
            r_flushed    <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
            load_valid_o <= 1'b0;
            load_data_o  <= 32'd0;
            bus_err_o    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            load_valid_o <= 1'b0;
            bus_err_o    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
            case (r_state)
                c_st_idle: begin
                    if (w_go) begin
                        r_state      <= c_st_req;
                        r_is_load    <= w_is_load;
                        r_flushed    <= 1'b0;
                        r_funct3     <= funct3_i;
                        r_addr_lo    <= addr_i[1:0];
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= w_is_store;
                        dmem_addr_o  <= {addr_i[31:2], 2'b00};
                        dmem_be_o    <= w_be;
                        dmem_wdata_o <= w_store_lanes;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (w_start & w_misaligned) begin
                        misalign_o <= 1'b1;
                    end
`endif
                end
                c_st_req: begin
                    // A grant wins over a simultaneous flush
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= r_is_load ? c_st_wait : c_st_done;
                    end else if (flush_i) begin
                        dmem_req_o <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end
                c_st_wait: begin
                    if (flush_i) begin
                        r_flushed <= 1'b1;
                    end
                    if (dmem_rvalid_i) begin
                        load_data_o  <= w_load_result;
                        load_valid_o <= ~(r_flushed | flush_i);
                        r_state      <= c_st_done;
                    end else if (r_wait_cnt == c_cnt_last) begin
                        bus_err_o  <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= c_st_idle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, flush_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, load_valid_o, bus_err_o;
    logic [31:0] load_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks   = 0;
    int failures = 0;
    int wait_cnt;
    logic seen_err, seen_lv;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .flush_i       (flush_i),
        .opcode_i      (opcode_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .load_valid_o  (load_valid_o),
        .load_data_o   (load_data_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o    (misalign_o),
`endif
        .bus_err_o     (bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        valid_i  = 1'b1;
        opcode_i = op;
        funct3_i = f3;
        addr_i   = a;
        wdata_i  = d;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; opcode_i = 7'd0;
        funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_load_valid", load_valid_o, 0);
        chk("rst_load_data", load_data_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        chk("rst_stall", stall_o, 0);
        cyc(); rst_n = 1'b1;

        // Non-memory opcode never stalls or requests
        cyc(); issue(OP_ALU, 3'b010, 32'h100, 32'h1); #1;
        chk("alu_stall", stall_o, 0);
        cyc(); valid_i = 1'b0; #1;
        chk("alu_no_req", dmem_req_o, 0);

        // SW 0x100, immediate gnt: 2 stall cycles
        cyc(); issue(OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF); #1;
        chk("sw_stall_c0", stall_o, 1);
        cyc(); valid_i = 1'b0; dmem_gnt_i = 1'b1; #1;
        chk("sw_req", dmem_req_o, 1);
        chk("sw_we", dmem_we_o, 1);
        chk("sw_addr", dmem_addr_o, 32'h100);
        chk("sw_be", dmem_be_o, 4'b1111);
        chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
        chk("sw_stall_c1", stall_o, 1);
        cyc(); dmem_gnt_i = 1'b0; #1;
        chk("sw_stall_c2", stall_o, 0);
        chk("sw_req_drop", dmem_req_o, 0);

        // LB from 0x103, rdata 0x80FFFFFF
        cyc(); issue(OP_LOAD, 3'b000, 32'h103, 32'h0); #1;
        chk("lb_stall_c0", stall_o, 1);
        cyc(); valid_i = 1'b0; dmem_gnt_i = 1'b1; #1;
        chk("lb_req", dmem_req_o, 1);
        chk("lb_we", dmem_we_o, 0);
        chk("lb_addr", dmem_addr_o, 32'h100);
        chk("lb_be", dmem_be_o, 4'b1000);
        cyc(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FFFFFF; #1;
        chk("lb_stall_wait", stall_o, 1);
        chk("lb_lv_early", load_valid_o, 0);
        cyc(); dmem_rvalid_i = 1'b0; #1;
        chk("lb_load_valid", load_valid_o, 1);
        chk("lb_load_data", load_data_o, 32'hFFFFFF80);
        chk("lb_stall_done", stall_o, 0);
        cyc(); #1;
        chk("lb_lv_pulse", load_valid_o, 0);

        // LBU on the same access
        issue(OP_LOAD, 3'b100, 32'h103, 32'h0);
        cyc(); valid_i = 1'b0; dmem_gnt_i = 1'b1;
        cyc(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FFFFFF;
        cyc(); dmem_rvalid_i = 1'b0; #1;
        chk("lbu_load_valid", load_valid_o, 1);
        chk("lbu_load_data", load_data_o, 32'h00000080);

        // SH to 0x102, gnt held off 3 cycles: 5 stall cycles
        cyc(); issue(OP_STORE, 3'b001, 32'h102, 32'h0000ABCD); #1;
        chk("sh_stall_c0", stall_o, 1);
        cyc(); valid_i = 1'b0; #1;
        chk("sh_be", dmem_be_o, 4'b1100);
        chk("sh_wdata_hi", {16'd0, dmem_wdata_o[31:16]}, 32'h0000ABCD);
        chk("sh_req_c1", dmem_req_o, 1);
        chk("sh_stall_c1", stall_o, 1);
        cyc(); #1;
        chk("sh_req_c2", dmem_req_o, 1);
        chk("sh_stall_c2", stall_o, 1);
        cyc(); #1;
        chk("sh_req_c3", dmem_req_o, 1);
        chk("sh_stall_c3", stall_o, 1);
        cyc(); dmem_gnt_i = 1'b1; #1;
        chk("sh_req_c4", dmem_req_o, 1);
        chk("sh_stall_c4", stall_o, 1);
        cyc(); dmem_gnt_i = 1'b0; #1;
        chk("sh_stall_c5", stall_o, 0);
        chk("sh_req_c5", dmem_req_o, 0);

        // LW with no rvalid: timeout after 64 WAIT cycles
        cyc(); issue(OP_LOAD, 3'b010, 32'h200, 32'h0); #1;
        chk("to_stall_c0", stall_o, 1);
        cyc(); valid_i = 1'b0; dmem_gnt_i = 1'b1; #1;
        chk("to_req", dmem_req_o, 1);
        wait_cnt = 0; seen_err = 1'b0; seen_lv = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(); dmem_gnt_i = 1'b0; #1;
            if (load_valid_o) seen_lv = 1'b1;
            if (bus_err_o) begin
                seen_err = 1'b1;
                break;
            end
            if (stall_o) wait_cnt++;
        end
        chk("to_bus_err_seen", seen_err, 1);
        chk("to_wait_cycles", wait_cnt, 64);
        chk("to_stall_released", stall_o, 0);
        chk("to_no_load_valid", seen_lv, 0);
        cyc(); #1;
        chk("to_err_pulse", bus_err_o, 0);

        // Flush in REQ before gnt: request dropped, no access
        cyc(); issue(OP_LOAD, 3'b010, 32'h300, 32'h0);
        cyc(); valid_i = 1'b0; flush_i = 1'b1; #1;
        chk("fr_req", dmem_req_o, 1);
        cyc(); flush_i = 1'b0; #1;
        chk("fr_req_drop", dmem_req_o, 0);
        chk("fr_stall", stall_o, 0);
        cyc(); dmem_gnt_i = 1'b1; #1;
        chk("fr_no_req", dmem_req_o, 0);
        cyc(); dmem_gnt_i = 1'b0; #1;
        chk("fr_idle_stall", stall_o, 0);

        // gnt together with flush counts as granted: load proceeds to WAIT
        cyc(); issue(OP_LOAD, 3'b010, 32'h304, 32'h0);
        cyc(); valid_i = 1'b0; flush_i = 1'b1; dmem_gnt_i = 1'b1;
        cyc(); flush_i = 1'b0; dmem_gnt_i = 1'b0; #1;
        chk("gf_in_wait", stall_o, 1);
        cyc(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0;
        cyc(); dmem_rvalid_i = 1'b0; #1;
        chk("gf_done", stall_o, 0);

        // Flush in WAIT: access completes, load_valid suppressed
        cyc(); issue(OP_LOAD, 3'b010, 32'h308, 32'h0);
        cyc(); valid_i = 1'b0; dmem_gnt_i = 1'b1;
        cyc(); dmem_gnt_i = 1'b0; flush_i = 1'b1; #1;
        chk("fw_stall_wait", stall_o, 1);
        cyc(); flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678; #1;
        chk("fw_stall_wait2", stall_o, 1);
        cyc(); dmem_rvalid_i = 1'b0; #1;
        chk("fw_no_load_valid", load_valid_o, 0);
        chk("fw_stall_done", stall_o, 0);

        // Reset mid-access drops the request at once
        cyc(); issue(OP_STORE, 3'b010, 32'h400, 32'h1);
        cyc(); valid_i = 1'b0; #1;
        chk("rm_req", dmem_req_o, 1);
        rst_n = 1'b0; #1;
        chk("rm_req_drop", dmem_req_o, 0);
        chk("rm_stall", stall_o, 0);
        cyc(); rst_n = 1'b1;

        // LW to 0x102 (misaligned word)
        cyc(); issue(OP_LOAD, 3'b010, 32'h102, 32'h0); #1;
        chk("mis_stall_c0", stall_o, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        cyc(); valid_i = 1'b0; #1;
        chk("mis_pulse", misalign_o, 1);
        chk("mis_no_req", dmem_req_o, 0);
        chk("mis_stall_c1", stall_o, 0);
        cyc(); #1;
        chk("mis_pulse_end", misalign_o, 0);
`else
        cyc(); valid_i = 1'b0; dmem_gnt_i = 1'b1; #1;
        chk("mis_req", dmem_req_o, 1);
        chk("mis_addr", dmem_addr_o, 32'h100);
        chk("mis_be", dmem_be_o, 4'b1111);
        cyc(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
        cyc(); dmem_rvalid_i = 1'b0; #1;
        chk("mis_load_data", load_data_o, 32'hCAFEF00D);
        chk("mis_load_valid", load_valid_o, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
